// File: rtl/rv32i_regfile_sequencer.sv
// rv32i_regfile_sequencer: arbitrates operand reads and write-back onto a 1R/1W register file, with x0 handling and a timeout.
// Optional RF_SEQ_SAME_SRC_SKIP_EN: when rs1==rs2 (nonzero) the register is read once and fanned out to both operands.
module rv32i_regfile_sequencer #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TMO_W          = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rd_req,
    input  logic [4:0]       i_rs1_addr,
    input  logic [4:0]       i_rs2_addr,
    output logic             o_rd_ack,
    output logic [WIDTH-1:0] o_rs1_data,
    output logic [WIDTH-1:0] o_rs2_data,
    input  logic             i_wb_req,
    input  logic [4:0]       i_wb_addr,
    input  logic [WIDTH-1:0] i_wb_data,
    output logic             o_wb_ack,
    output logic             o_rf_rd_en,
    output logic [4:0]       o_rf_reg_addr,
    input  logic [WIDTH-1:0] i_rf_reg_data,
    input  logic             i_rf_rd_valid,
    output logic             o_rf_wr_en,
    output logic [4:0]       o_rf_dest_addr,
    output logic [WIDTH-1:0] o_rf_dest_data,
    input  logic             i_rf_wr_valid,
    output logic             o_err
);
    typedef enum logic [2:0] {IDLE, WRITE, READ1, GAP, READ2, ACK} state_t;

    state_t           state, state_nx;
    logic [TMO_W-1:0] cnt;
    logic [4:0]       rs1, rs2, cur_rs;
    logic [WIDTH-1:0] rs1_val, rd_val;
    logic             wb_go, reading, rd_wait, wr_wait, done, timeout, skip;

`ifdef RF_SEQ_SAME_SRC_SKIP_EN
    assign skip = rs1 == rs2;
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        cur_rs         = state == READ2 ? rs2 : rs1;
        reading        = state == READ1 || state == READ2;
        rd_wait        = reading && cur_rs != '0;
        wr_wait        = state == WRITE;
        done           = (rd_wait && i_rf_rd_valid) || (wr_wait && i_rf_wr_valid) || (reading && cur_rs == '0);
        timeout        = (rd_wait || wr_wait) && !done && cnt == TMO_W'(TIMEOUT_CYCLES - 1);
        rd_val         = cur_rs == '0 ? '0 : i_rf_reg_data;
        // the ack cycle still sees the old request held high, so it must not start a second write
        wb_go          = i_wb_req && !o_wb_ack;
        state_nx       = state;
        case (state)
            IDLE:    state_nx = wb_go ? (i_wb_addr != '0 ? WRITE : IDLE) : i_rd_req ? READ1 : IDLE;
            WRITE:   state_nx = done || timeout ? IDLE : WRITE;
            READ1:   state_nx = timeout ? IDLE : !done ? READ1 : skip && rs1 != '0 ? ACK : GAP;
            GAP:     state_nx = READ2;
            READ2:   state_nx = timeout ? IDLE : done ? ACK : READ2;
            default: state_nx = IDLE;
        endcase
        o_rf_rd_en     = rd_wait;
        o_rf_reg_addr  = rd_wait ? cur_rs : '0;
        o_rf_wr_en     = wr_wait;
        o_rf_dest_addr = wr_wait ? i_wb_addr : '0;
        o_rf_dest_data = wr_wait ? i_wb_data : '0;
        o_rd_ack       = state == ACK;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rs1        <= '0;
            rs2        <= '0;
            rs1_val    <= '0;
            o_rs1_data <= '0;
            o_rs2_data <= '0;
            o_wb_ack   <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= (rd_wait || wr_wait) && state_nx == state ? cnt + 1'b1 : '0;
            o_wb_ack <= (state == IDLE && wb_go && i_wb_addr == '0) || (wr_wait && done);
            o_err    <= o_err || timeout;
            if (state == IDLE && state_nx == READ1) begin
                rs1 <= i_rs1_addr;
                rs2 <= i_rs2_addr;
            end
            if (state == READ1 && state_nx == GAP)
                rs1_val <= rd_val;
            // both operands change together on entry to ACK so they stay stable between acks
            if (state_nx == ACK) begin
                o_rs1_data <= state == READ1 ? rd_val : rs1_val;
                o_rs2_data <= rd_val;
            end
        end
    end
endmodule

// File: tb/tb_rv32i_regfile_sequencer.sv
// tb_rv32i_regfile_sequencer: directed bench with a register-file responder and a reference register model.
// Honours RF_SEQ_SAME_SRC_SKIP_EN when the design is built with it.
module tb_rv32i_regfile_sequencer;
    localparam int W = 32;
`ifdef RF_SEQ_SAME_SRC_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic         i_rd_req = 1'b0;
    logic [4:0]   i_rs1_addr = '0;
    logic [4:0]   i_rs2_addr = '0;
    logic         o_rd_ack;
    logic [W-1:0] o_rs1_data, o_rs2_data;
    logic         i_wb_req = 1'b0;
    logic [4:0]   i_wb_addr = '0;
    logic [W-1:0] i_wb_data = '0;
    logic         o_wb_ack;
    logic         o_rf_rd_en;
    logic [4:0]   o_rf_reg_addr;
    logic [W-1:0] i_rf_reg_data;
    logic         i_rf_rd_valid;
    logic         o_rf_wr_en;
    logic [4:0]   o_rf_dest_addr;
    logic [W-1:0] o_rf_dest_data;
    logic         i_rf_wr_valid;
    logic         o_err;

    always #5 i_clk = ~i_clk;

    rv32i_regfile_sequencer dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_rd_req(i_rd_req), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_rd_ack(o_rd_ack), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
        .i_wb_req(i_wb_req), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_wb_ack(o_wb_ack),
        .o_rf_rd_en(o_rf_rd_en), .o_rf_reg_addr(o_rf_reg_addr), .i_rf_reg_data(i_rf_reg_data),
        .i_rf_rd_valid(i_rf_rd_valid), .o_rf_wr_en(o_rf_wr_en), .o_rf_dest_addr(o_rf_dest_addr),
        .o_rf_dest_data(o_rf_dest_data), .i_rf_wr_valid(i_rf_wr_valid), .o_err(o_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return i == 0 ? 32'h0 : i == 5 ? 32'h12345678 : i == 6 ? 32'hCAFEF00D : 32'h10000000 + i * 32'h01010101;
    endfunction

    // register file: read/write valid two cycles after the enable rises; stall withholds read valid
    logic [W-1:0] rf_mem [32];
    int           rcnt = 0;
    int           wcnt = 0;
    logic         stall = 1'b0;
    assign i_rf_rd_valid = o_rf_rd_en && rcnt == 2 && !stall;
    assign i_rf_reg_data = o_rf_rd_en ? rf_mem[o_rf_reg_addr] : '0;
    assign i_rf_wr_valid = o_rf_wr_en && wcnt == 2;

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = init_val(i);
        forever begin
            @(posedge i_clk);
            rcnt <= o_rf_rd_en ? rcnt + 1 : 0;
            wcnt <= o_rf_wr_en ? wcnt + 1 : 0;
            if (i_rf_wr_valid) rf_mem[o_rf_dest_addr] <= o_rf_dest_data;
        end
    end

    // reference model: architectural register values and the read bursts each request should cause
    logic [W-1:0] ref_regs [32];
    logic [4:0]   bursts[$];
    logic [4:0]   exp_q[$];
    logic         prev_rd = 1'b0;
    logic         prev_err = 1'b0;
    int           wr_cycles = 0;

    initial begin
        for (int i = 0; i < 32; i++) ref_regs[i] = init_val(i);
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                bursts.delete();
                prev_rd = 1'b0;
                prev_err = 1'b0;
                wr_cycles = 0;
            end else begin
                check("en_exclusive", {31'b0, o_rf_rd_en & o_rf_wr_en}, 32'h0);
                if (o_rf_rd_en && !prev_rd) bursts.push_back(o_rf_reg_addr);
                else if (o_rf_rd_en && bursts.size() > 0) check("rd_addr_stable", {27'b0, o_rf_reg_addr}, {27'b0, bursts[$]});
                if (o_rf_wr_en) wr_cycles++;
                if (o_err && !prev_err) bursts.delete();
                if (o_rd_ack) begin
                    exp_q.delete();
                    if (i_rs1_addr != 0) exp_q.push_back(i_rs1_addr);
                    if (i_rs2_addr != 0 && !(SKIP && i_rs1_addr == i_rs2_addr)) exp_q.push_back(i_rs2_addr);
                    check("rd_burst_count", bursts.size(), exp_q.size());
                    for (int k = 0; k < exp_q.size() && k < bursts.size(); k++)
                        check("rd_burst_addr", {27'b0, bursts[k]}, {27'b0, exp_q[k]});
                    check("rs1_model", o_rs1_data, ref_regs[i_rs1_addr]);
                    check("rs2_model", o_rs2_data, ref_regs[i_rs2_addr]);
                    bursts.delete();
                end
                if (o_wb_ack) begin
                    if (i_wb_addr != 0) begin
                        check("wb_committed", rf_mem[i_wb_addr], i_wb_data);
                        check("wb_used_port", {31'b0, wr_cycles != 0}, 32'h1);
                        ref_regs[i_wb_addr] = i_wb_data;
                    end else begin
                        check("wb_x0_no_access", wr_cycles, 0);
                    end
                    wr_cycles = 0;
                end
                prev_rd = o_rf_rd_en;
                prev_err = o_err;
            end
        end
    end

    task automatic do_read(input logic [4:0] a, input logic [4:0] b, output int lat, output logic [W-1:0] d1, output logic [W-1:0] d2);
        @(negedge i_clk);
        i_rd_req = 1'b1;
        i_rs1_addr = a;
        i_rs2_addr = b;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge i_clk);
            if (o_rd_ack) begin
                lat = n;
                break;
            end
        end
        i_rd_req = 1'b0;
        d1 = o_rs1_data;
        d2 = o_rs2_data;
        check("rd_ack_seen", {31'b0, lat != 0}, 32'h1);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [W-1:0] d, output int lat, output int wr_cnt);
        @(negedge i_clk);
        i_wb_req = 1'b1;
        i_wb_addr = a;
        i_wb_data = d;
        lat = 0;
        wr_cnt = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge i_clk);
            if (o_wb_ack) begin
                lat = n;
                break;
            end
            if (o_rf_wr_en) wr_cnt++;
        end
        i_wb_req = 1'b0;
        check("wb_ack_seen", {31'b0, lat != 0}, 32'h1);
    endtask

    int           lat, wl, rl, cnt;
    logic [W-1:0] d1, d2;
    logic         seen, acked;

    initial begin
        #1;
        check("rst_rd_en", {31'b0, o_rf_rd_en}, 32'h0);
        check("rst_wr_en", {31'b0, o_rf_wr_en}, 32'h0);
        check("rst_acks", {30'b0, o_rd_ack, o_wb_ack}, 32'h0);
        check("rst_err", {31'b0, o_err}, 32'h0);
        check("rst_rs1", o_rs1_data, 32'h0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;

        do_read(5'd5, 5'd6, lat, d1, d2);
        check("pair_lat", lat, 8);
        check("pair_rs1", d1, 32'h12345678);
        check("pair_rs2", d2, 32'hCAFEF00D);

        do_write(5'd10, 32'hA5A50F0F, lat, cnt);
        check("wb_lat", lat, 4);
        check("wb_en_cycles", cnt, 3);
        do_read(5'd10, 5'd5, lat, d1, d2);
        check("raw_rs1", d1, 32'hA5A50F0F);
        check("raw_rs2", d2, 32'h12345678);

        do_write(5'd0, 32'hFFFFFFFF, lat, cnt);
        check("wb_x0_lat", lat, 1);
        check("wb_x0_en_cycles", cnt, 0);
        do_read(5'd0, 5'd7, lat, d1, d2);
        check("x0_lat", lat, 6);
        check("x0_rs1", d1, 32'h0);
        check("x0_rs2", d2, 32'h17070707);
        do_read(5'd0, 5'd0, lat, d1, d2);
        check("x0x0_lat", lat, 4);
        check("x0x0_data", d1 | d2, 32'h0);

        @(negedge i_clk);
        i_wb_req = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'hDEADBEEF;
        i_rd_req = 1'b1; i_rs1_addr = 5'd5; i_rs2_addr = 5'd5;
        wl = 0; rl = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge i_clk);
            if (o_wb_ack && wl == 0) begin
                wl = n;
                i_wb_req = 1'b0;
            end
            if (o_rd_ack) begin
                rl = n;
                break;
            end
        end
        i_wb_req = 1'b0;
        i_rd_req = 1'b0;
        check("sim_wb_lat", wl, 4);
        check("sim_rd_lat", rl, SKIP ? 8 : 12);
        check("sim_rs1", o_rs1_data, 32'hDEADBEEF);
        check("sim_rs2", o_rs2_data, 32'hDEADBEEF);

        do_read(5'd9, 5'd9, lat, d1, d2);
        check("same_src_lat", lat, SKIP ? 4 : 8);
        check("same_src_rs1", d1, 32'h19090909);
        check("same_src_rs2", d2, 32'h19090909);

        stall = 1'b1;
        @(negedge i_clk);
        i_rd_req = 1'b1; i_rs1_addr = 5'd3; i_rs2_addr = 5'd4;
        cnt = 0; seen = 1'b0; acked = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge i_clk);
            if (o_rd_ack) acked = 1'b1;
            if (o_err) begin
                seen = 1'b1;
                break;
            end
            if (o_rf_rd_en) cnt++;
        end
        check("tmo_err_set", {31'b0, seen}, 32'h1);
        check("tmo_wait_cycles", cnt, 15);
        check("tmo_rd_en_dropped", {31'b0, o_rf_rd_en}, 32'h0);
        check("tmo_no_ack", {31'b0, acked}, 32'h0);
        stall = 1'b0;
        seen = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge i_clk);
            if (o_rd_ack) begin
                seen = 1'b1;
                break;
            end
        end
        i_rd_req = 1'b0;
        check("retry_ack", {31'b0, seen}, 32'h1);
        check("retry_rs1", o_rs1_data, 32'h13030303);
        check("retry_rs2", o_rs2_data, 32'h14040404);
        repeat (3) @(negedge i_clk);
        check("err_sticky", {31'b0, o_err}, 32'h1);

        stall = 1'b1;
        @(negedge i_clk);
        i_rd_req = 1'b1; i_rs1_addr = 5'd5; i_rs2_addr = 5'd6;
        repeat (3) @(negedge i_clk);
        check("pre_rst_rd_en", {31'b0, o_rf_rd_en}, 32'h1);
        #2 i_rst = 1'b0;
        #1;
        check("arst_rd_en", {31'b0, o_rf_rd_en}, 32'h0);
        check("arst_rd_ack", {31'b0, o_rd_ack}, 32'h0);
        check("arst_err", {31'b0, o_err}, 32'h0);
        check("arst_data", o_rs1_data | o_rs2_data, 32'h0);
        i_rd_req = 1'b0;
        stall = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        acked = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            if (o_rd_ack || o_rf_rd_en) acked = 1'b1;
        end
        check("post_rst_quiet", {31'b0, acked}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
